// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the palindrome generator and its mirror network.
package palindrome_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Widest palindrome the mirror helper supports.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned half_width(input int unsigned width);
        return (width + 1) / 2;
    endfunction

    // Seed bits at or above half_width(width) must be zero. For odd widths the
    // middle bit overlaps itself, so it shows up only once.
    function automatic logic [MAX_W-1:0] mirror_word(input logic [MAX_W-1:0] seed,
                                                     input int unsigned     width);
        logic [MAX_W-1:0] rev;
        rev = {<<{seed}};
        return seed | (rev >> (MAX_W - width));
    endfunction

endpackage

// File: rtl/palindrome_mirror.sv
// Combinational seed -> WIDTH-bit bit-palindrome expansion.
module palindrome_mirror
    import palindrome_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned HALF  = half_width(WIDTH)
) (
    input  logic [HALF-1:0]  seed,
    output logic [WIDTH-1:0] word
);

    always_comb begin
        word = WIDTH'(mirror_word(MAX_W'(seed), WIDTH));
    end

endmodule

// File: rtl/palindrome_gen.sv
// Serial palindrome transmitter: accepts a half-word seed and streams the
// mirrored WIDTH-bit word one bit per beat, index 0 first.
module palindrome_gen
    import palindrome_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned HALF  = half_width(WIDTH),
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HALF-1:0]  in_seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [WIDTH-1:0] pal_word,
    output logic             busy
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    idx_nxt;
    logic [WIDTH-1:0] mirror_w;
    logic             accept;
    logic             beat;

    palindrome_mirror #(
        .WIDTH (WIDTH)
    ) u_mirror (
        .seed (in_seed),
        .word (mirror_w)
    );

    // A new seed may land on the final beat so frames run with no bubble.
    always_comb begin
        in_ready = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
        accept   = in_valid && in_ready;
        beat     = out_valid && out_ready;
        idx_nxt  = idx + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pal_word  <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= SEND;
            idx       <= '0;
            pal_word  <= mirror_w;
            out_valid <= 1'b1;
            out_bit   <= mirror_w[0];
            out_last  <= 1'b0;
            busy      <= 1'b1;
        end else if (beat) begin
            if (out_last) begin
                state     <= IDLE;
                idx       <= '0;
                out_valid <= 1'b0;
                out_bit   <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                idx      <= idx_nxt;
                out_bit  <= pal_word[idx_nxt];
                out_last <= (idx_nxt == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_palindrome_gen.sv
// Directed bench for palindrome_gen at WIDTH=16 and WIDTH=7.
module tb_palindrome_gen;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_seed;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic        out_last;
    logic [15:0] pal_word;
    logic        busy;

    logic        v7_in_valid;
    logic        v7_in_ready;
    logic [3:0]  v7_seed;
    logic        v7_out_valid;
    logic        v7_out_ready;
    logic        v7_out_bit;
    logic        v7_out_last;
    logic [6:0]  v7_pal_word;
    logic        v7_busy;

    int errors = 0;
    int checks = 0;

    palindrome_gen #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_seed   (in_seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .pal_word  (pal_word),
        .busy      (busy)
    );

    palindrome_gen #(.WIDTH(7)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v7_in_valid),
        .in_ready  (v7_in_ready),
        .in_seed   (v7_seed),
        .out_valid (v7_out_valid),
        .out_ready (v7_out_ready),
        .out_bit   (v7_out_bit),
        .out_last  (v7_out_last),
        .pal_word  (v7_pal_word),
        .busy      (v7_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model16(input logic [7:0] s);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i]      = s[i];
            w[15 - i] = s[i];
        end
        return w;
    endfunction

    initial begin
        logic [15:0] exp16;
        logic [6:0]  exp7;
        logic [15:0] got;
        logic [15:0] rev;
        logic [7:0]  s;
        logic        stalled;
        logic        pbit;
        logic        plast;
        logic        done;
        int          cnt;

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_seed      = '0;
        out_ready    = 1'b0;
        v7_in_valid  = 1'b0;
        v7_seed      = '0;
        v7_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pal_word",  32'(pal_word),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_bit",   32'(out_bit),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready),  32'd1);
        chk("idle_valid",    32'(out_valid), 32'd0);

        // Seed 0x0F -> 0xF00F, latency 1
        out_ready = 1'b1;
        in_seed   = 8'h0F;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_valid_lat", 32'(out_valid), 32'd1);
        chk("t1_pal_word",  32'(pal_word),  32'hF00F);
        chk("t1_busy",      32'(busy),      32'd1);
        exp16 = 16'hF00F;
        for (int b = 0; b < 16; b++) begin
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_bit",   32'(out_bit),   32'(exp16[b]));
            chk("t1_last",  32'(out_last),  32'(b == 15));
            @(negedge clk);
        end
        chk("t1_end_valid", 32'(out_valid), 32'd0);
        chk("t1_end_busy",  32'(busy),      32'd0);
        chk("t1_end_hold",  32'(pal_word),  32'hF00F);
        chk("t1_end_ready", 32'(in_ready),  32'd1);

        // Odd width: seed 4'b1001 -> 7'h49, middle bit once
        v7_out_ready = 1'b1;
        v7_seed      = 4'b1001;
        v7_in_valid  = 1'b1;
        @(negedge clk);
        v7_in_valid = 1'b0;
        chk("w7_pal_word", 32'(v7_pal_word), 32'h49);
        exp7 = 7'b1001001;
        for (int b = 0; b < 7; b++) begin
            chk("w7_valid", 32'(v7_out_valid), 32'd1);
            chk("w7_bit",   32'(v7_out_bit),   32'(exp7[b]));
            chk("w7_last",  32'(v7_out_last),  32'(b == 6));
            @(negedge clk);
        end
        chk("w7_end_valid", 32'(v7_out_valid), 32'd0);
        chk("w7_end_busy",  32'(v7_busy),      32'd0);

        // Back-to-back: 0x01 then 0x03 with no idle cycle
        in_seed  = 8'h01;
        in_valid = 1'b1;
        @(negedge clk);
        in_seed = 8'h03;
        chk("b2b_ready_mid", 32'(in_ready), 32'd0);
        for (int b = 0; b < 32; b++) begin
            exp16 = (b < 16) ? 16'h8001 : 16'hC003;
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_bit",   32'(out_bit),   32'(exp16[b % 16]));
            chk("b2b_last",  32'(out_last),  32'((b % 16) == 15));
            if (b == 15) chk("b2b_ready_last", 32'(in_ready), 32'd1);
            if (b == 16) chk("b2b_pal_word2",  32'(pal_word), 32'hC003);
            @(negedge clk);
            if (b == 15) in_valid = 1'b0;
        end
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // Random backpressure with seed 0xA6 -> 0x65A6; seed changed after accept
        in_seed  = 8'hA6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_seed  = 8'h00;
        got      = '0;
        cnt      = 0;
        stalled  = 1'b0;
        pbit     = 1'b0;
        plast    = 1'b0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (stalled) begin
                chk("bp_hold_bit",  32'(out_bit),  32'(pbit));
                chk("bp_hold_last", 32'(out_last), 32'(plast));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready && out_valid) begin
                if (cnt < 16) got[cnt] = out_bit;
                cnt++;
                if (out_last) done = 1'b1;
            end
            stalled = !out_ready;
            pbit    = out_bit;
            plast   = out_last;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("bp_done",  32'(done), 32'd1);
        chk("bp_count", 32'(cnt),  32'd16);
        chk("bp_word",  32'(got),  32'h65A6);

        // Reset at beat 5 aborts the frame
        in_seed  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rm_pal_word", 32'(pal_word), 32'h5A5A);
        repeat (5) @(negedge clk);
        chk("rm_beat5_bit", 32'(out_bit), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_valid",    32'(out_valid), 32'd0);
        chk("rm_busy",     32'(busy),      32'd0);
        chk("rm_pal_word0", 32'(pal_word), 32'd0);
        chk("rm_last",     32'(out_last),  32'd0);
        chk("rm_in_ready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_post_valid", 32'(out_valid), 32'd0);
        chk("rm_post_ready", 32'(in_ready),  32'd1);
        in_seed  = 8'h81;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp16 = 16'h8181;
        for (int b = 0; b < 16; b++) begin
            chk("rm_new_valid", 32'(out_valid), 32'd1);
            chk("rm_new_bit",   32'(out_bit),   32'(exp16[b]));
            chk("rm_new_last",  32'(out_last),  32'(b == 15));
            @(negedge clk);
        end
        chk("rm_new_end", 32'(out_valid), 32'd0);

        // Random seeds: collected stream matches model and is a palindrome
        for (int k = 0; k < 200; k++) begin
            s        = 8'($urandom);
            in_seed  = s;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_seed  = ~s;
            got      = '0;
            for (int b = 0; b < 16; b++) begin
                got[b] = out_bit;
                @(negedge clk);
            end
            rev = {<<{got}};
            chk("rnd_word", 32'(got), 32'(model16(s)));
            chk("rnd_pal",  32'(got), 32'(rev));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palindrome_gen.md
Name: palindrome_gen

Overview:
Serial palindrome transmitter. Accepts a half-word seed over a valid/ready handshake, builds the WIDTH-bit bit-palindrome it defines, and streams that word out one bit per beat with valid/ready/last. The full word is also presented in parallel. It is the producing end paired with the palindrome_bits checker. It sources test and framing patterns that downstream checkers must flag as palindromes.

Parameters:
WIDTH, 16, total palindrome length in bits; legal values are 2 or more, odd or even.
HALF, (WIDTH+1)/2, seed width, derived and not overridden; for odd WIDTH, seed[HALF-1] is the middle bit.
CW, $clog2(WIDTH), bit-index counter width.

Ports:
clk  in  1  rising-edge clock, the only clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  seed offered.
in_ready  out  1  generator can accept a seed this cycle.
in_seed  in  HALF  seed; defines p[i]=seed[i] and p[WIDTH-1-i]=seed[i] for i<HALF.
out_valid  out  1  out_bit is valid.
out_ready  in  1  sink accepts out_bit this cycle.
out_bit  out  1  current palindrome bit p[idx], sent from index 0 upward.
out_last  out  1  high with the beat where idx==WIDTH-1.
pal_word  out  WIDTH  full palindrome of the frame in flight; holds its value after the frame ends.
busy  out  1  frame in progress (state==SEND).

Behaviour:
- Reset is synchronous, active-high, sampled on the clk rising edge. Everything is synchronous to clk.
- Reset values: state=IDLE, idx=0, pal_word=0, out_valid=0, out_bit=0, out_last=0, busy=0. While rst=1, in_ready=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1, out_bit=pal_word[idx], out_last=(idx==WIDTH-1).
- Accept condition: in_valid && in_ready.
  - pal_word <= mirror(in_seed), idx <= 0, state <= SEND.
  - First out_valid appears the cycle after accept (latency 1).
- Beat condition: out_valid && out_ready, then idx <= idx+1.
  - On the last beat with no new accept: state <= IDLE, idx <= 0.
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - A seed accepted on the last beat starts the next frame with no bubble. Sustained throughput is WIDTH bits per WIDTH cycles.
- Backpressure: while out_ready=0, out_bit, out_last, idx and pal_word hold stable. Valid is never withdrawn.
- in_seed is sampled only on accept; later changes have no effect on the frame in flight.
- Odd WIDTH: the middle bit p[HALF-1] comes from seed[HALF-1] and is emitted once.
- Wrap: idx never exceeds WIDTH-1 and never wraps mid-frame.
- Reset mid-frame: the frame is aborted with no further beats. The next cycle shows the reset values above.
- Emitted order is palindromic, so MSB-first and LSB-first sinks see an identical stream.

Decomposition:
- palindrome_pkg holds:
  - state enum {IDLE, SEND};
  - function mirror_word(seed, WIDTH);
  - HALF derivation constant.
- One combinational sub-module, palindrome_mirror (seed -> WIDTH-bit word), shared with the checker bench. The FSM, counter and handshake stay in palindrome_gen.

Test Plan:
- Reset, then WIDTH=16, seed 8'h0F accepted at cycle N -> out_valid at N+1; pal_word=16'hF00F; stream 1111 0000 0000 1111 over 16 beats; out_last only on beat 16; busy drops after it.
- WIDTH=7, seed 4'b1001 -> pal_word=7'h49; stream 1,0,0,1,0,0,1; middle bit emitted once.
- WIDTH=16, seeds 8'h01 then 8'h03 held valid -> second seed accepted on the last beat of frame 1; streams for 16'h8001 then 16'hC003 run with zero idle cycles (32 beats in 32 cycles).
- Random out_ready (50%) with seed 8'hA6 -> out_bit and out_last stable whenever out_ready=0; collected word equals 16'h65A6.
- rst asserted at beat 5 of a frame -> next cycle out_valid=0, busy=0, pal_word=0; after rst drops, a new seed starts cleanly from idx 0.
- Every emitted word fed into palindrome_bits (same WIDTH, 1000 random seeds) -> is_palindrome=1 always.
